// File: rtl/frame_config_loader.sv
// Frame configuration loader: hunts for a sync word in a 32-bit stream, then
// decodes header/data pairs into FrameData plus a single-cycle FrameStrobe.
//
// state  | meaning
// IDLE   | hunting for sync word, non-sync words discarded
// HEADER | waiting for header (address) or end-of-bitstream word
// DATA   | waiting for frame payload word
// STROBE | one-cycle write strobe for the latched address, input stalled
module frame_config_loader #(
  parameter int FRAME_BITS     = 32,
  parameter int FRAMES_PER_COL = 20,
  parameter int NUM_COLS       = 16
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic [31:0]                          s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [FRAME_BITS-1:0]                FrameData,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0]   FrameStrobe,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [15:0]                          frames_written
);

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam int          NUM_STROBES = NUM_COLS * FRAMES_PER_COL;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  colReg;
  logic [4:0]  frameReg;
  logic        accept;
  logic        addrOk;
  logic        syncSeen;
  logic        endSeen;
  logic        dataLoad;
  logic        dataReject;
  logic [31:0] strobeIdx;

  assign accept     = s_valid && s_ready;
  assign addrOk     = ({1'b0, colReg} < 9'(NUM_COLS)) &&
                      ({1'b0, frameReg} < 6'(FRAMES_PER_COL));
  assign syncSeen   = (state == IDLE) && accept && (s_data == SYNC_WORD);
  assign endSeen    = (state == HEADER) && accept && s_data[31];
  assign dataLoad   = (state == DATA) && accept && addrOk;
  assign dataReject = (state == DATA) && accept && !addrOk;
  assign strobeIdx  = 32'(colReg) * 32'(FRAMES_PER_COL) + 32'(frameReg);

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    s_ready   = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (syncSeen) stateNext = HEADER;
      end
      HEADER: begin
        if (accept) stateNext = s_data[31] ? IDLE : DATA;
      end
      DATA: begin
        if (accept) stateNext = addrOk ? STROBE : HEADER;
      end
      STROBE: begin
        s_ready   = 1'b0;
        stateNext = HEADER;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Strobe decodes from state and the latched address only, so a reset that
  // forces IDLE removes it without waiting for a clock.
  always_comb begin
    FrameStrobe = '0;
    for (int i = 0; i < NUM_STROBES; i++) begin
      FrameStrobe[i] = (state == STROBE) && (strobeIdx == 32'(i));
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      colReg   <= '0;
      frameReg <= '0;
    end else if ((state == HEADER) && accept && !s_data[31]) begin
      colReg   <= s_data[15:8];
      frameReg <= s_data[4:0];
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      FrameData <= '0;
    end else if (dataLoad) begin
      FrameData <= s_data[FRAME_BITS-1:0];
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      done <= 1'b0;
    end else begin
      done <= endSeen;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (syncSeen) begin
      err <= 1'b0;
    end else if (dataReject) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frames_written <= '0;
    end else if (syncSeen) begin
      frames_written <= '0;
    end else if ((state == STROBE) && (frames_written != 16'hFFFF)) begin
      frames_written <= frames_written + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_config_loader.sv
// Directed self-checking bench for frame_config_loader.
module tb_frame_config_loader;

  localparam int NS = 320;

  logic          UserCLK;
  logic          resetn;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   FrameData;
  logic [NS-1:0] FrameStrobe;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   frames_written;

  int checks = 0;
  int errors = 0;

  frame_config_loader #(
    .FRAME_BITS(32),
    .FRAMES_PER_COL(20),
    .NUM_COLS(16)
  ) dut (
    .UserCLK(UserCLK),
    .resetn(resetn),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .done(done),
    .err(err),
    .frames_written(frames_written)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    s_data  = w;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) tick();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b done=%b err=%b, want 1 0 0 0", s_ready, busy, done, err);
    end
    checks++;
    if (FrameData !== 32'h0 || FrameStrobe !== '0 || frames_written !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: FrameData=%h strobe=%h fw=%0d, want all zero", FrameData, FrameStrobe, frames_written);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ready=%b, want 0 1", busy, s_ready);
    end
  endtask

  task automatic test_sync_hunt();
    sendWord(32'h1234_5678);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hunt_discard: busy=%b, want 0", busy);
    end
    sendWord(32'hFAB0_FAB1);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL hunt_sync: busy=%b ready=%b, want 1 1", busy, s_ready);
    end
  endtask

  task automatic test_single_frame();
    logic [NS-1:0] expStrobe;
    expStrobe = '0;
    expStrobe[65] = 1'b1;
    sendWord(32'h0000_0305);
    checks++;
    if (FrameStrobe !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_header: strobe=%h busy=%b, want 0 1", FrameStrobe, busy);
    end
    sendWord(32'hDEAD_BEEF);
    checks++;
    if (FrameData !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_data: FrameData=%h, want deadbeef", FrameData);
    end
    checks++;
    if (FrameStrobe !== expStrobe) begin
      errors++;
      $display("FAIL single_strobe: strobe=%h, want %h", FrameStrobe, expStrobe);
    end
    checks++;
    if (s_ready !== 1'b0 || frames_written !== 16'd0) begin
      errors++;
      $display("FAIL single_strobe_ctrl: ready=%b fw=%0d, want 0 0", s_ready, frames_written);
    end
    tick();
    checks++;
    if (FrameStrobe !== '0 || frames_written !== 16'd1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_after: strobe=%h fw=%0d ready=%b, want 0 1 1", FrameStrobe, frames_written, s_ready);
    end
    sendWord(32'h8000_0000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: done=%b busy=%b, want 1 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]   pres [14];
    int            strobeBit [14];
    logic [NS-1:0] expStrobe;
    pres = '{32'hFAB0_FAB1, 32'h0000_0013, 32'hA0A0_0000, 32'h0000_0113,
             32'h0000_0113, 32'hA0A0_0001, 32'h0000_0213, 32'h0000_0213,
             32'hA0A0_0002, 32'h0000_0313, 32'h0000_0313, 32'hA0A0_0003,
             32'h8000_0000, 32'h8000_0000};
    strobeBit = '{-1, -1, -1, 19, -1, -1, 39, -1, -1, 59, -1, -1, 79, -1};
    for (int i = 0; i < 14; i++) begin
      s_data  = pres[i];
      s_valid = 1'b1;
      expStrobe = '0;
      if (strobeBit[i] >= 0) expStrobe[strobeBit[i]] = 1'b1;
      checks++;
      if (FrameStrobe !== expStrobe || s_ready !== (strobeBit[i] < 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cycle%0d: strobe=%h ready=%b done=%b, want %h %b 0",
                 i, FrameStrobe, s_ready, done, expStrobe, (strobeBit[i] < 0));
      end
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || frames_written !== 16'd4 || FrameData !== 32'hA0A0_0003) begin
      errors++;
      $display("FAIL b2b_end: done=%b busy=%b fw=%0d data=%h, want 1 0 4 a0a00003", done, busy, frames_written, FrameData);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_once: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_address_errors();
    logic [NS-1:0] expStrobe;
    sendWord(32'hFAB0_FAB1);
    sendWord(32'h0000_1000);
    sendWord(32'h1111_1111);
    checks++;
    if (err !== 1'b1 || FrameStrobe !== '0 || FrameData !== 32'hA0A0_0003 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_col: err=%b strobe=%h data=%h ready=%b, want 1 0 a0a00003 1", err, FrameStrobe, FrameData, s_ready);
    end
    sendWord(32'h0000_0014);
    sendWord(32'h2222_2222);
    checks++;
    if (err !== 1'b1 || FrameStrobe !== '0 || FrameData !== 32'hA0A0_0003 || frames_written !== 16'd0) begin
      errors++;
      $display("FAIL err_frame: err=%b strobe=%h data=%h fw=%0d, want 1 0 a0a00003 0", err, FrameStrobe, FrameData, frames_written);
    end
    expStrobe = '0;
    expStrobe[319] = 1'b1;
    sendWord(32'h0000_0F13);
    sendWord(32'hCAFE_F00D);
    checks++;
    if (FrameStrobe !== expStrobe || FrameData !== 32'hCAFE_F00D || err !== 1'b1) begin
      errors++;
      $display("FAIL err_then_valid: strobe=%h data=%h err=%b, want %h cafef00d 1", FrameStrobe, FrameData, err, expStrobe);
    end
    tick();
    checks++;
    if (frames_written !== 16'd1) begin
      errors++;
      $display("FAIL err_fw: fw=%0d, want 1", frames_written);
    end
    sendWord(32'h8000_0000);
    sendWord(32'hFAB0_FAB1);
    checks++;
    if (err !== 1'b0 || frames_written !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_resync: err=%b fw=%0d busy=%b, want 0 0 1", err, frames_written, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [NS-1:0] expStrobe;
    expStrobe = '0;
    expStrobe[22] = 1'b1;
    sendWord(32'h0000_0102);
    sendWord(32'h55AA_55AA);
    checks++;
    if (FrameStrobe !== expStrobe) begin
      errors++;
      $display("FAIL mid_strobe: strobe=%h, want %h", FrameStrobe, expStrobe);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (FrameStrobe !== '0 || busy !== 1'b0 || s_ready !== 1'b1 || FrameData !== 32'h0 || frames_written !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: strobe=%h busy=%b ready=%b data=%h fw=%0d, want 0 0 1 0 0",
               FrameStrobe, busy, s_ready, FrameData, frames_written);
    end
    tick();
    resetn = 1'b1;
    tick();
    sendWord(32'h0000_0305);
    checks++;
    if (busy !== 1'b0 || FrameStrobe !== '0) begin
      errors++;
      $display("FAIL mid_discard: busy=%b strobe=%h, want 0 0", busy, FrameStrobe);
    end
    sendWord(32'hFAB0_FAB1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_resync: busy=%b, want 1", busy);
    end
    sendWord(32'h8000_0000);
  endtask

  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    test_reset();
    test_sync_hunt();
    test_single_frame();
    test_back_to_back();
    test_address_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
